// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Stall/squash controller for a 5-stage IF/ID/EX/MEM/WB integer+FP pipeline
// that has no forwarding paths and redirects control flow from the EX/MEM
// boundary. A three-entry scoreboard tracks destination tags in flight in
// EX, MEM and WB. The instruction in ID is checked against that scoreboard
// for RAW hazards. Instructions in the control shadow are squashed.
//
// Ports:
//   clock          system clock
//   reset          synchronous, active-high reset
//   id_valid       ID holds a real instruction (0 = bubble)
//   id_rs1         source A tag {is_fp, idx[4:0]}
//   id_rs1_used    source A is read
//   id_rs2         source B tag
//   id_rs2_used    source B is read
//   id_rd          destination tag
//   id_rd_write    instruction writes id_rd
//   id_is_ctrl     branch/jump/JAL/JR/JALR
//   hold_if_id     PC and IF/ID keep their value this edge
//   bubble_ex      ID/EX loads a NOP this edge
//   shadow_active  control shadow counter is nonzero
//   stall_count    saturating count of cycles with hold_if_id=1

module pipe_hazard_ctrl #(
    parameter int CTRL_SHADOW = 3,
    parameter int WB_BYPASS   = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [5:0]       id_rs1,
    input  logic             id_rs1_used,
    input  logic [5:0]       id_rs2,
    input  logic             id_rs2_used,
    input  logic [5:0]       id_rd,
    input  logic             id_rd_write,
    input  logic             id_is_ctrl,
    output logic             hold_if_id,
    output logic             bubble_ex,
    output logic             shadow_active,
    output logic [CNT_W-1:0] stall_count
);

    // Keep the counter at least one bit wide even if the shadow is disabled.
    localparam int SH_W = (CTRL_SHADOW > 0) ? $clog2(CTRL_SHADOW + 1) : 1;
    localparam logic [SH_W-1:0] SH_LOAD = SH_W'(CTRL_SHADOW);
    localparam logic CHECK_WB = (WB_BYPASS == 0);

    logic            sb_ex_v;
    logic [5:0]      sb_ex_tag;
    logic            sb_mem_v;
    logic [5:0]      sb_mem_tag;
    logic            sb_wb_v;
    logic [5:0]      sb_wb_tag;
    logic [SH_W-1:0] shadow_cnt;

    logic rs1_match;
    logic rs2_match;
    logic raw;
    logic squash;
    logic issue;

    // The WB entry only counts as a hazard when the register file cannot
    // write and read the same register in one cycle.
    always_comb begin
        rs1_match = id_rs1_used &&
                    ((sb_ex_v  && (sb_ex_tag  == id_rs1)) ||
                     (sb_mem_v && (sb_mem_tag == id_rs1)) ||
                     (CHECK_WB && sb_wb_v && (sb_wb_tag == id_rs1)));
        rs2_match = id_rs2_used &&
                    ((sb_ex_v  && (sb_ex_tag  == id_rs2)) ||
                     (sb_mem_v && (sb_mem_tag == id_rs2)) ||
                     (CHECK_WB && sb_wb_v && (sb_wb_tag == id_rs2)));
    end

    // Squash takes priority over a RAW stall. A wrong-path instruction
    // is discarded, so a false match on it must not hold the front end.
    always_comb begin
        raw           = id_valid && (rs1_match || rs2_match);
        squash        = (shadow_cnt != '0);
        issue         = id_valid && !squash && !raw;
        hold_if_id    = raw && !squash;
        bubble_ex     = squash || raw;
        shadow_active = squash;
    end

    // The scoreboard shifts every edge. A stall or squash cycle inserts an
    // invalid entry, so a held instruction enters EX only once. Integer r0
    // is never tracked. FP f0 (6'b100000) is tracked like any other tag.
    always_ff @(posedge clock) begin
        if (reset) begin
            sb_ex_v    <= 1'b0;
            sb_ex_tag  <= '0;
            sb_mem_v   <= 1'b0;
            sb_mem_tag <= '0;
            sb_wb_v    <= 1'b0;
            sb_wb_tag  <= '0;
        end else begin
            sb_wb_v    <= sb_mem_v;
            sb_wb_tag  <= sb_mem_tag;
            sb_mem_v   <= sb_ex_v;
            sb_mem_tag <= sb_ex_tag;
            sb_ex_v    <= issue && id_rd_write && (id_rd != 6'd0);
            sb_ex_tag  <= id_rd;
        end
    end

    // A control instruction starts its shadow only on the edge it actually
    // issues, so one that is held by a RAW hazard has not started it yet.
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_cnt <= '0;
        end else if (issue && id_is_ctrl) begin
            shadow_cnt <= SH_LOAD;
        end else if (shadow_cnt != '0) begin
            shadow_cnt <= shadow_cnt - SH_W'(1);
        end
    end

    // The stall counter saturates at all-ones instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= '0;
        end else if (hold_if_id && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule
